// File: rtl/fifo_wr_packer.sv
// Write-domain packer: gathers RATIO narrow beats into one FIFO word and drives the
// FIFO write port. Frame-final words are padded with PAD_VALUE in the unused lanes.
module fifo_wr_packer #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    IN_WIDTH    = 4,
    parameter logic [IN_WIDTH-1:0]   PAD_VALUE   = '0,
    parameter int                    COUNT_WIDTH = 16
) (
    input  logic                   wr_clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic                   in_last,
    output logic                   wr_inc,
    output logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_full,
    output logic [COUNT_WIDTH-1:0] words_written,
    output logic [COUNT_WIDTH-1:0] frames_done
);

    localparam int RATIO = DATA_WIDTH / IN_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    // Handshakes: input beat moves when in_valid && in_ready on a rising edge;
    // a FIFO word moves when wr_inc && !wr_full on a rising edge.
    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    out_state_t             state_q, state_d;
    logic [IDX_W-1:0]       idx;
    logic [DATA_WIDTH-1:0]  asm_q;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   out_last;
    logic                   out_valid;
    logic                   push;
    logic                   accept;
    logic                   completing;
    logic [DATA_WIDTH-1:0]  word;

    assign out_valid  = (state_q == OUT_FULL);
    assign push       = out_valid && !wr_full;
    assign in_ready   = ((idx != LAST_IDX) && !in_last) || !out_valid || push;
    assign accept     = in_valid && in_ready;
    assign completing = accept && ((idx == LAST_IDX) || in_last);

    assign wr_inc  = out_valid;
    assign wr_data = out_data;

    // Current lane takes the beat; on a frame end, every lane above it takes the pad.
    always_comb begin
        word = asm_q;
        for (int l = 0; l < RATIO; l++) begin
            if (IDX_W'(l) == idx) begin
                word[l*IN_WIDTH +: IN_WIDTH] = in_data;
            end else if ((IDX_W'(l) > idx) && in_last) begin
                word[l*IN_WIDTH +: IN_WIDTH] = PAD_VALUE;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: if (completing)         state_d = OUT_FULL;
            OUT_FULL:  if (push && !completing) state_d = OUT_EMPTY;
            default:                           state_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= OUT_EMPTY;
            idx      <= '0;
            asm_q    <= '0;
            out_data <= '0;
            out_last <= 1'b0;
        end else begin
            state_q <= state_d;
            if (completing) begin
                idx      <= '0;
                asm_q    <= '0;
                out_data <= word;
                out_last <= in_last;
            end else if (accept) begin
                idx   <= idx + 1'b1;
                asm_q <= word;
            end
        end
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            words_written <= '0;
            frames_done   <= '0;
        end else if (push) begin
            if (words_written != {COUNT_WIDTH{1'b1}}) begin
                words_written <= words_written + 1'b1;
            end
            if (out_last && (frames_done != {COUNT_WIDTH{1'b1}})) begin
                frames_done <= frames_done + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed bench for fifo_wr_packer with default parameters (8-bit words, 4-bit beats).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_fifo_wr_packer;

    logic        wr_clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_data;
    logic        in_last;
    logic        wr_inc;
    logic [7:0]  wr_data;
    logic        wr_full;
    logic [15:0] words_written;
    logic [15:0] frames_done;

    int tests;
    int fails;
    logic [7:0] exp_words[4];

    fifo_wr_packer #(
        .DATA_WIDTH (8),
        .IN_WIDTH   (4),
        .PAD_VALUE  (4'h0),
        .COUNT_WIDTH(16)
    ) dut (
        .wr_clk       (wr_clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .wr_inc       (wr_inc),
        .wr_data      (wr_data),
        .wr_full      (wr_full),
        .words_written(words_written),
        .frames_done  (frames_done)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_words[0] = 8'h10;
        exp_words[1] = 8'h32;
        exp_words[2] = 8'h54;
        exp_words[3] = 8'h76;
        rst_n   = 1'b0;
        wr_full = 1'b0;
        drive(1'b0, 4'h0, 1'b0);

        // Reset values
        tick();
        tick();
        check("rst_wr_inc", wr_inc, 0);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_words", words_written, 0);
        check("rst_frames", frames_done, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // Two beats pack into 0xA5
        drive(1'b1, 4'h5, 1'b0);
        tick();
        drive(1'b1, 4'hA, 1'b0);
        check("pack_ready", in_ready, 1);
        tick();
        drive(1'b0, 4'h0, 1'b0);
        check("pack_inc", wr_inc, 1);
        check("pack_data", wr_data, 8'hA5);
        check("pack_words_pre", words_written, 0);
        tick();
        check("pack_inc_low", wr_inc, 0);
        check("pack_words", words_written, 1);
        check("pack_frames", frames_done, 0);

        // Single-beat frame is padded
        drive(1'b1, 4'h3, 1'b1);
        tick();
        drive(1'b0, 4'h0, 1'b0);
        check("pad_inc", wr_inc, 1);
        check("pad_data", wr_data, 8'h03);
        tick();
        check("pad_inc_low", wr_inc, 0);
        check("pad_words", words_written, 2);
        check("pad_frames", frames_done, 1);

        // Back-pressure: wr_full held across six edges
        wr_full = 1'b1;
        drive(1'b1, 4'h1, 1'b0);
        tick();
        drive(1'b1, 4'h2, 1'b0);
        tick();
        drive(1'b1, 4'h3, 1'b0);
        check("bp_data_21", wr_data, 8'h21);
        check("bp_inc_hi", wr_inc, 1);
        check("bp_ready_3", in_ready, 1);
        tick();
        drive(1'b1, 4'h4, 1'b0);
        check("bp_stall_4", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_data", wr_data, 8'h21);
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_words", words_written, 2);
        end
        wr_full = 1'b0;
        #1;
        check("bp_release_ready", in_ready, 1);
        tick();
        drive(1'b0, 4'h0, 1'b0);
        check("bp_reload_inc", wr_inc, 1);
        check("bp_reload_data", wr_data, 8'h43);
        check("bp_words_3", words_written, 3);
        tick();
        check("bp_inc_low", wr_inc, 0);
        check("bp_words_4", words_written, 4);
        check("bp_frames", frames_done, 1);

        // Continuous stream 0..7, no back-pressure
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'(i), 1'b0);
            #1;
            check("strm_ready", in_ready, 1);
            tick();
            if (i % 2 == 1) begin
                check("strm_inc_hi", wr_inc, 1);
                check("strm_data", wr_data, exp_words[i/2]);
            end else begin
                check("strm_inc_lo", wr_inc, 0);
            end
        end
        drive(1'b0, 4'h0, 1'b0);
        tick();
        check("strm_words", words_written, 8);
        check("strm_inc_end", wr_inc, 0);

        // Reset mid-word discards the partial beat
        drive(1'b1, 4'hF, 1'b0);
        tick();
        drive(1'b0, 4'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_words", words_written, 0);
        check("mid_rst_inc", wr_inc, 0);
        tick();
        rst_n = 1'b1;
        tick();
        drive(1'b1, 4'h9, 1'b0);
        tick();
        drive(1'b1, 4'h8, 1'b0);
        tick();
        drive(1'b0, 4'h0, 1'b0);
        check("post_rst_inc", wr_inc, 1);
        check("post_rst_data", wr_data, 8'h89);
        tick();
        check("post_rst_words", words_written, 1);
        check("post_rst_inc_lo", wr_inc, 0);
        check("post_rst_frames", frames_done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
